// File: rtl/tt_sweep_pkg.sv
// Shared types and sizes for the truth-table sweep driver.
package tt_sweep_pkg;
  localparam int N_VEC = 16;
  localparam int IDX_W = 4;
  localparam int ERR_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/tt_settle_cnt.sv
// Loadable down-counter that times how long each vector settles before sampling.
module tt_settle_cnt
  import tt_sweep_pkg::*;
#(
  parameter int W = IDX_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load has priority; otherwise count down while enabled, stopping at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/tt_sweep_driver.sv
// Sweeps all 16 {a,b,c,d} vectors into a 4-input DUT, captures s per vector
// and compares the captured table against EXPECTED.
// Optional first-mismatch logging is enabled by defining TT_SWEEP_ERRLOG_EN.
module tt_sweep_driver
  import tt_sweep_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECTED      = 16'hAC3C
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             s,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      resp,
`ifdef TT_SWEEP_ERRLOG_EN
  output logic             first_err_vld,
  output logic [IDX_W-1:0] first_err_idx,
`endif
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [IDX_W-1:0] SETTLE_LOAD = IDX_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_VEC - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             last_vec;
  logic             mismatch;
  logic             cnt_load;
  logic             cnt_zero;

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_vec = (idx == LAST_IDX);
  assign mismatch = (s != EXPECTED[idx]);
  assign cnt_load = accept || ((state == SAMPLE) && !last_vec);

  tt_settle_cnt #(
    .W(IDX_W)
  ) u_settle_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .en       (state == DRIVE),
    .load_val (SETTLE_LOAD),
    .zero     (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: settle in DRIVE, sample once, then advance or finish.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   if (cnt_zero) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = last_vec ? DONE : DRIVE;
      DONE:    if (start) state_nxt = DRIVE;
      default: state_nxt = IDLE;
    endcase
  end

  // Vector index, response capture and mismatch count; cleared on each accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx     <= '0;
      resp    <= '0;
      err_cnt <= '0;
    end else if (accept) begin
      idx     <= '0;
      resp    <= '0;
      err_cnt <= '0;
    end else if (state == SAMPLE) begin
      resp[idx] <= s;
      if (mismatch) err_cnt <= err_cnt + ERR_W'(1);
      if (!last_vec) idx <= idx + IDX_W'(1);
    end
  end

`ifdef TT_SWEEP_ERRLOG_EN
  // Latch the index of the first mismatching vector of the current sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
    end else if (accept) begin
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
    end else if ((state == SAMPLE) && mismatch && !first_err_vld) begin
      first_err_vld <= 1'b1;
      first_err_idx <= idx;
    end
  end
`endif

  assign {a, b, c, d} = idx;
  assign busy         = (state == DRIVE) || (state == SAMPLE);
  assign done         = (state == DONE);
  assign pass         = done && (err_cnt == '0);

endmodule
